uart_tx_fsm: RTL and testbench
==============================

Name: uart_tx_fsm

Overview:
- UART transmitter; the transmit-side counterpart of the UART receive FSM.
- Accepts a parallel word via a valid strobe and serialises it LSB-first as start bit, DATA_WIDTH data bits, an optional parity bit, and one stop bit.
- Bit timing comes from the shared oversampled baud tick, with OVERSAMPLE ticks per bit, so TX and RX share one baud generator.
- Sits between the system-side data source and the TX pad.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
OVERSAMPLE, 16, TX_tick pulses per serial bit period (must be >= 2)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel word to send
DATA_VALID  input  1  request strobe; P_DATA is captured when accepted
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_tick  input  1  one-CLK pulse at OVERSAMPLE x baud rate
TX_OUT  output  1  serial line, idle high, registered
BUSY  output  1  high while a frame is in flight, registered

Behaviour:
- Reset (RST low, asynchronous): state=IDLE, TX_OUT=1, BUSY=0, tick counter=0, bit counter=0, shift register=0, parity flag=0.
- Clock and reset: single clock domain; the polarity and synchronicity of RST are fixed as above.
- States: IDLE, START, DATA, PARITY, STOP.
- Tick counter:
  - Width ceil(log2(OVERSAMPLE)).
  - Increments only on CLK edges where TX_tick=1 and state!=IDLE.
  - Wraps to 0 after OVERSAMPLE-1.
- bit_end is the cycle where TX_tick=1 and tick counter = OVERSAMPLE-1. All state transitions except the one out of IDLE occur on bit_end.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - On a CLK edge with DATA_VALID=1, the block captures P_DATA into the shift register and captures PAR_EN.
  - It also computes the parity flag = (^P_DATA) XOR PAR_TYP.
  - It clears the tick and bit counters and moves to START.
  - On the following cycle, TX_OUT=0 and BUSY=1 (one-cycle acceptance latency).
- START: TX_OUT=0. On bit_end, move to DATA.
- DATA:
  - TX_OUT = shift register bit 0.
  - On bit_end, shift right by one and increment the bit counter.
  - When the bit counter reaches DATA_WIDTH-1 at bit_end, move to PARITY if the captured PAR_EN=1, else to STOP.
- PARITY: TX_OUT = parity flag. On bit_end, move to STOP.
- STOP:
  - TX_OUT=1.
  - On bit_end, move to IDLE; BUSY=0 from the next cycle.
- Frame length: exactly (2 + DATA_WIDTH + PAR_EN) x OVERSAMPLE TX_tick pulses from the start-bit edge to the return to IDLE.
- DATA_VALID handling:
  - Ignored whenever the state is not IDLE, including the bit_end cycle of STOP, where BUSY is still 1.
  - No queueing; the source must wait for BUSY=0.
- Input capture: P_DATA, PAR_EN and PAR_TYP are sampled only at acceptance. Changes mid-frame have no effect on the current frame.
- Back-to-back frames: DATA_VALID held high is accepted on the first IDLE cycle. This gives exactly one CLK cycle of idle-high between frames, plus tick alignment.
- TX_tick gaps: TX_tick=0 for arbitrary cycles simply stretches the current bit. TX_OUT must hold steady.
- Reset mid-frame: the line returns high and BUSY clears asynchronously. The partial frame is abandoned, and no residual state carries into the next frame.
- Glitch freedom: TX_OUT is driven from a flop, never combinationally from state.
- Unused state encodings recover to IDLE with TX_OUT=1.

Test Plan:
- Even parity, 0xA5 (DATA_WIDTH=8, OVERSAMPLE=16, TX_tick every cycle, PAR_EN=1, PAR_TYP=0): pulse DATA_VALID with P_DATA=0xA5.
  - TX_OUT line: 0, 1,0,1,0,0,1,0,1, 0, 1.
  - Each bit is 16 cycles wide; BUSY is high for 176 cycles.
- Odd parity, 0x00 (PAR_EN=1, PAR_TYP=1): parity bit = 1. Frame: 0, eight 0s, 1, 1.
- No parity, 0xFF (PAR_EN=0): frame 0, eight 1s, 1. BUSY is high for 160 cycles, and there is no ninth post-data bit.
- Mid-frame DATA_VALID: assert DATA_VALID with P_DATA=0x3C during the DATA state of a 0xA5 frame -> frame is unchanged, and no second frame is started.
- Back-to-back: hold DATA_VALID high with 0x55 then 0xAA -> two complete frames separated by exactly one idle-high cycle. BUSY drops for exactly that one cycle.
- Tick throttling and reset:
  - TX_tick every 4th cycle -> each bit lasts 64 CLK cycles.
  - Drive RST low during bit 3 -> TX_OUT=1 and BUSY=0 immediately.
  - After release, a new 0x81 frame transmits correctly.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// UART transmitter: serialises a parallel word LSB-first as start bit, data
// bits, optional parity bit and one stop bit. Bit timing comes from the shared
// oversampled baud tick, OVERSAMPLE ticks per serial bit.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  TX_tick,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int TickW = $clog2(OVERSAMPLE);
  localparam int BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [TickW-1:0]      tickCnt_q, tickCnt_d;
  logic [BitW-1:0]       bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  parEn_q, parEn_d;
  logic                  txOut_q, txOut_d;
  logic                  busy_q, busy_d;
  logic                  bitEnd;

  assign bitEnd = TX_tick && (tickCnt_q == TickLast);
  assign TX_OUT = txOut_q;
  assign BUSY   = busy_q;

  // State, datapath and registered line/busy outputs; reset forces an idle-high line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      tickCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      parEn_q   <= 1'b0;
      txOut_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tickCnt_q <= tickCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      parEn_q   <= parEn_d;
      txOut_q   <= txOut_d;
      busy_q    <= busy_d;
    end
  end

  // Next state: leave IDLE on a request, every other transition waits for the end of a bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (DATA_VALID) state_d = START;
      START:   if (bitEnd) state_d = DATA;
      DATA:    if (bitEnd && (bitCnt_q == BitLast)) state_d = parEn_q ? PARITY : STOP;
      PARITY:  if (bitEnd) state_d = STOP;
      STOP:    if (bitEnd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture the word and frame options on acceptance, then count ticks and shift bits.
  always_comb begin
    tickCnt_d = tickCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    parEn_d   = parEn_q;
    if (state_q == IDLE) begin
      if (DATA_VALID) begin
        shift_d   = P_DATA;
        parEn_d   = PAR_EN;
        parity_d  = (^P_DATA) ^ PAR_TYP;
        tickCnt_d = '0;
        bitCnt_d  = '0;
      end
    end else begin
      if (TX_tick) begin
        tickCnt_d = bitEnd ? '0 : tickCnt_q + TickW'(1);
      end
      if ((state_q == DATA) && bitEnd) begin
        shift_d  = shift_q >> 1;
        bitCnt_d = bitCnt_q + BitW'(1);
      end
    end
  end

  // Outputs are decoded from the upcoming state so the flops present them aligned with it.
  always_comb begin
    txOut_d = 1'b1;
    busy_d  = (state_d != IDLE);
    case (state_d)
      START:   txOut_d = 1'b0;
      DATA:    txOut_d = shift_d[0];
      PARITY:  txOut_d = parity_d;
      STOP:    txOut_d = 1'b1;
      default: txOut_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: directed frames plus randomized frames,
// compared every cycle against a frame-level reference model.
module tb_uart_tx_fsm;

  localparam int DW = 8;
  localparam int OS = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_tick = 1'b0;
  logic          TX_OUT;
  logic          BUSY;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the expected frame as a list of line levels, plus the
  // number of ticks seen since acceptance; line = bits[ticks / OS].
  logic mBusy = 1'b0;
  int   mTicks = 0;
  int   mLen = 0;
  int   mAccepts = 0;
  logic mBits [0:15];

  int tickPeriod = 1;
  int tickPhase = 0;

  uart_tx_fsm #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .CLK(CLK),
    .RST(RST),
    .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .TX_tick(TX_tick),
    .TX_OUT(TX_OUT),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic expLine();
    if (!mBusy) return 1'b1;
    return mBits[mTicks / OS];
  endfunction

  task automatic modelStep(input logic v, input logic [DW-1:0] d, input logic pe, input logic pt, input logic tk);
    int ones;
    if (!mBusy) begin
      if (v) begin
        mBusy = 1'b1;
        mTicks = 0;
        mAccepts++;
        mBits[0] = 1'b0;
        for (int i = 0; i < DW; i++) mBits[1 + i] = d[i];
        mLen = DW + 2;
        if (pe) begin
          ones = $countones(d);
          mBits[DW + 1] = ((ones + int'(pt)) % 2) == 1;
          mLen++;
        end
        mBits[mLen - 1] = 1'b1;
      end
    end else if (tk) begin
      mTicks++;
      if (mTicks == mLen * OS) mBusy = 1'b0;
    end
  endtask

  task automatic genTick(output logic tk);
    if (tickPeriod == 0) begin
      tk = ($urandom_range(0, 2) == 0);
    end else begin
      tk = (tickPhase == 0);
      tickPhase = (tickPhase + 1) % tickPeriod;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic pe, input logic pt);
    logic tk;
    genTick(tk);
    DATA_VALID = v;
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    TX_tick = tk;
    @(posedge CLK);
    #1;
    modelStep(v, d, pe, pt, tk);
    checkOutput("txOut", {31'b0, TX_OUT}, {31'b0, expLine()});
    checkOutput("busy", {31'b0, BUSY}, {31'b0, mBusy});
  endtask

  task automatic applyNoise(input logic noisyValid);
    logic v;
    v = noisyValid ? ($urandom_range(0, 7) == 0) : 1'b0;
    applyStimulus(v, DW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic runFrame(input logic [DW-1:0] d, input logic pe, input logic pt,
                          input int expBusy, input logic noisyValid);
    int busyCycles;
    int guard;
    busyCycles = 0;
    guard = 0;
    applyStimulus(1'b1, d, pe, pt);
    busyCycles += int'(BUSY);
    while (mBusy && guard < 5000) begin
      applyNoise(noisyValid);
      busyCycles += int'(BUSY);
      guard++;
    end
    if (mBusy) checkOutput("frameTimeout", 32'd0, 32'd1);
    if (expBusy > 0) checkOutput("busyLen", busyCycles, expBusy);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyNoise(1'b0);
  endtask

  initial begin
    int gap;
    int guard;
    int startAcc;
    logic [DW-1:0] rd;
    logic rpe;

    // Asynchronous reset before any clock edge
    #1 RST = 1'b0;
    #2;
    checkOutput("resetTx", {31'b0, TX_OUT}, 32'd1);
    checkOutput("resetBusy", {31'b0, BUSY}, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    checkOutput("resetTxHeld", {31'b0, TX_OUT}, 32'd1);
    checkOutput("resetBusyHeld", {31'b0, BUSY}, 32'd0);
    #2 RST = 1'b1;

    tickPeriod = 1;
    idleCycles(3);

    // Even parity 0xA5, odd parity 0x00, no parity 0xFF
    runFrame(8'hA5, 1'b1, 1'b0, 176, 1'b0);
    idleCycles(2);
    runFrame(8'h00, 1'b1, 1'b1, 176, 1'b0);
    idleCycles(2);
    runFrame(8'hFF, 1'b0, 1'b0, 160, 1'b0);
    idleCycles(20);

    // Request during the DATA state of a frame is ignored
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < OS * 3; i++) applyNoise(1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1);
    guard = 0;
    while (mBusy && guard < 5000) begin
      applyNoise(1'b0);
      guard++;
    end
    if (mBusy) checkOutput("midFrameTimeout", 32'd0, 32'd1);
    idleCycles(20);

    // Back-to-back with DATA_VALID held high
    startAcc = mAccepts;
    gap = 0;
    guard = 0;
    while ((mAccepts - startAcc) < 2 && guard < 2000) begin
      applyStimulus(1'b1, ((mAccepts - startAcc) == 0) ? 8'h55 : 8'hAA, 1'b1, 1'b0);
      if ((mAccepts - startAcc) == 1 && BUSY === 1'b0) gap++;
      guard++;
    end
    if ((mAccepts - startAcc) < 2) checkOutput("b2bTimeout", 32'd0, 32'd1);
    checkOutput("b2bGap", gap, 32'd1);
    guard = 0;
    while (mBusy && guard < 5000) begin
      applyNoise(1'b0);
      guard++;
    end
    idleCycles(5);

    // Throttled tick, reset during data bit 3, then a clean 0x81 frame
    tickPeriod = 4;
    tickPhase = 0;
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
    guard = 0;
    while (mBusy && mTicks < (4 * OS + 8) && guard < 2000) begin
      applyNoise(1'b0);
      guard++;
    end
    #2 RST = 1'b0;
    #1;
    checkOutput("midRstTx", {31'b0, TX_OUT}, 32'd1);
    checkOutput("midRstBusy", {31'b0, BUSY}, 32'd0);
    mBusy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checkOutput("rstHoldTx", {31'b0, TX_OUT}, 32'd1);
      checkOutput("rstHoldBusy", {31'b0, BUSY}, 32'd0);
    end
    #2 RST = 1'b1;
    tickPhase = 0;
    runFrame(8'h81, 1'b0, 1'b0, 640, 1'b0);
    idleCycles(5);

    // Randomized frames with varying tick density and mid-frame input noise
    for (int f = 0; f < 25; f++) begin
      tickPeriod = $urandom_range(0, 3);
      tickPhase = 0;
      rd = DW'($urandom);
      rpe = 1'($urandom);
      runFrame(rd, rpe, 1'($urandom), (tickPeriod == 1) ? (2 + DW + int'(rpe)) * OS : 0, 1'b1);
      idleCycles($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
